popcnt_seq_arb: RTL

//  Shares one 8-bit ones-count unit between NREQ requesters. Each requester

---
 rtl/popcnt_seq_arb_if.sv | 27 ++
 rtl/popcnt_seq_arb.sv | 131 +++++++++++++
 2 files changed

// File: rtl/popcnt_seq_arb_if.sv
// Request/response bundle for popcnt_seq_arb: NREQ word requesters plus one
// result channel carrying the owning requester ID and the ones count.
interface popcnt_seq_arb_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IW-1:0]         rsp_id;
   logic [CW-1:0]         rsp_count;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_count
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_count
   );
endinterface

// File: rtl/popcnt_seq_arb.sv
// Round-robin shared byte-serial popcount: accepts one word, counts it a byte per cycle, returns the total.
// Optional POPCNT_EARLY_EXIT_EN: leave RUN as soon as the remaining shifted bits are all zero.
//
// state | meaning
// IDLE  | arbitrating, req_ready one-hot to the round-robin winner
// RUN   | counting one byte of the latched word per cycle
// RESP  | result presented, waiting for rsp_ready
module popcnt_seq_arb #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   popcnt_seq_arb_if.slave  bus,
   output logic             busy
);
   localparam int NB = WIDTH / 8;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  shreg;
   logic [CW-1:0]     acc;
   logic [IW-1:0]     id;
   logic [IW-1:0]     rr_ptr;
   logic [PW-1:0]     pass_cnt;

   logic [NREQ-1:0]   grant;
   logic [IW-1:0]     gnt_idx;
   logic [WIDTH-1:0]  gnt_word;
   logic              accept;
   logic              last_pass;
   logic [3:0]        byte_ones;

   // Scan from lowest to highest priority so the highest-priority valid requester is written last.
   always_comb begin : arb
      int idx;
      grant    = '0;
      gnt_idx  = '0;
      gnt_word = '0;
      idx      = 0;
      if (state == IDLE) begin
         for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (bus.req_valid[idx]) begin
               grant        = '0;
               grant[idx]   = 1'b1;
               gnt_idx      = IW'(idx);
               gnt_word     = bus.req_data[idx*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign accept = |(bus.req_valid & grant);

   always_comb begin
      byte_ones = '0;
      for (int i = 0; i < 8; i++) begin
         byte_ones = byte_ones + {3'b000, shreg[i]};
      end
   end

   always_comb begin
      state_nxt = state;
      last_pass = (pass_cnt == PW'(NB - 1));
`ifdef POPCNT_EARLY_EXIT_EN
      if ((shreg >> 8) == '0) begin
         last_pass = 1'b1;
      end
`endif
      case (state)
         IDLE:    if (accept)        state_nxt = RUN;
         RUN:     if (last_pass)     state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg    <= '0;
         acc      <= '0;
         id       <= '0;
         rr_ptr   <= IW'(NREQ - 1);
         pass_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg    <= gnt_word;
                  acc      <= '0;
                  id       <= gnt_idx;
                  rr_ptr   <= gnt_idx;
                  pass_cnt <= '0;
               end
            end
            RUN: begin
               acc      <= acc + CW'(byte_ones);
               shreg    <= shreg >> 8;
               pass_cnt <= pass_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // acc is frozen outside RUN, so the result holds steady for the whole RESP phase.
   assign bus.req_ready = grant;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = id;
   assign bus.rsp_count = acc;
   assign busy          = (state != IDLE);

endmodule
